bmd_256_latency_ctrl: RTL and testbench
=======================================

BMD_256_LATENCY_CTRL -- requirements
Module: BMD_256_latency_ctrl

Interface
REQ-001 SHALL have parameters: CNT_W, 38, timestamp/latency width; ADDR_W, 13, tag/BRAM address width (8192 entries).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, 250 MHz; the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- latency_reset_signal, in, 1, synchronous user clear.
- latency_counter, in, CNT_W, free-running timestamp.
- tx_send_valid, in, 1, TX engine sends an echo packet.
- tx_send_ready, out, 1, tag available.
- tx_tag, out, ADDR_W, tag for the current send (= wr_ptr).
- rx_echo_valid, in, 1, echo returned.
- rx_echo_ready, out, 1, controller can accept an echo.
- rx_echo_tag, in, ADDR_W, tag carried by the echo.
- bram_ena, out, 1, BRAM port A enable.
- bram_wea, out, 1, BRAM port A write enable.
- bram_wr_addr, out, ADDR_W, BRAM port A address.
- bram_wr_data, out, CNT_W, BRAM port A data.
- bram_reb, out, 1, BRAM port B enable.
- bram_rd_addr, out, ADDR_W, BRAM port B address.
- bram_rd_data, in, CNT_W, BRAM port B data (2-cycle read latency).
- lat_valid, out, 1, one-cycle strobe with each result.
- lat_value, out, CNT_W, latest latency.
- lat_min, out, CNT_W, minimum latency.
- lat_max, out, CNT_W, maximum latency.
- lat_sum, out, 54, latency sum.
- lat_count, out, 32, number of results.
- outstanding, out, ADDR_W+1, sends not yet echoed.
- err_unexpected, out, 1, sticky error.

Function
REQ-003 SHALL accept a send when tx_send_valid && tx_send_ready; tx_send_ready = (outstanding < 8192).
REQ-004 SHALL write on the cycle after an accepted send: bram_ena = bram_wea = 1; bram_wr_addr = tag; bram_wr_data = latency_counter sampled in the accept cycle. bram_ena and bram_wea SHALL be 0 otherwise.
REQ-005 SHALL increment wr_ptr by 1 per accepted send, wrapping 8191 -> 0.
REQ-006 SHALL implement a read FSM with states IDLE, RD, W1, W2. rx_echo_ready = (state == IDLE).
REQ-007 SHALL handle an accepted echo in IDLE with outstanding > 0 as follows: capture rx_echo_tag and latency_counter (t_rx), then go to RD.
REQ-008 SHALL, in RD: bram_reb = 1, bram_rd_addr = captured tag, then go to W1 -> W2. In W2, bram_rd_data is valid; compute the result and return to IDLE.
REQ-009 SHALL compute lat_value = (t_rx - bram_rd_data) mod 2^CNT_W, so counter wrap yields the correct difference. The result SHALL be registered; lat_valid SHALL pulse 1 cycle, 4 cycles after echo accept.
REQ-010 SHALL update statistics on each result: min/max compare against lat_value; lat_sum += lat_value, saturating at all-ones; lat_count += 1, saturating at 2^32-1.
REQ-011 SHALL update outstanding as follows: +1 on send accept, -1 on echo accept; simultaneous send and echo SHALL leave it unchanged.
REQ-012 SHALL handle an echo accepted with outstanding == 0 as follows: set err_unexpected; do not issue a read or produce a result; FSM stays IDLE; outstanding stays 0.
REQ-013 SHALL keep bram_reb = 0 outside RD. Earliest echo (cycle after send) reads 2 cycles after accept, after the write of REQ-004; no read-before-write hazard.
REQ-014 SHALL, on latency_reset_signal (synchronous, priority over all events in that cycle), clear wr_ptr, outstanding, stats and err_unexpected to reset values and force the FSM to IDLE. An in-flight read SHALL be discarded (no lat_valid).

Reset
REQ-015 SHALL, while rst_n = 0 (asynchronous), hold: all BRAM enables 0; addresses/data 0; lat_valid 0; lat_value 0; lat_min all-ones; lat_max 0; lat_sum 0; lat_count 0; outstanding 0; err_unexpected 0; wr_ptr 0; FSM IDLE. After reset, tx_send_ready = 1 and rx_echo_ready = 1.

Verification
REQ-016 Single echo: send at counter=100 (tag 0), echo tag 0 at counter=350 -> bram write addr 0 data 100; lat_valid 4 cycles after echo accept; lat_value=250; min=max=250; count=1.
REQ-017 Wrap: send at counter=2^38-10, echo at counter=5 -> lat_value=15.
REQ-018 Full: 8192 sends without echo -> tx_send_ready=0 and outstanding=8192; one echo -> ready=1, next tag 0.
REQ-019 Unexpected: echo with outstanding=0 -> err_unexpected=1, bram_reb never asserted, no lat_valid.
REQ-020 Simultaneous send+echo, then latency_reset_signal 1 cycle after an echo accept -> outstanding unchanged by the send+echo; after clear, no lat_valid, all stats at reset values, tx_tag=0.

Source files
------------

// File: rtl/bmd_256_latency_ctrl.sv
// Echo-latency controller: stamps each send into BRAM by tag, and on each echo reads the
// stamp back, computes the round-trip latency and keeps min/max/sum/count statistics.
module bmd_256_latency_ctrl #(
    parameter int unsigned CNT_W  = 38,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              latency_reset_signal,
    input  logic [CNT_W-1:0]  latency_counter,
    input  logic              tx_send_valid,
    output logic              tx_send_ready,
    output logic [ADDR_W-1:0] tx_tag,
    input  logic              rx_echo_valid,
    output logic              rx_echo_ready,
    input  logic [ADDR_W-1:0] rx_echo_tag,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [CNT_W-1:0]  bram_wr_data,
    output logic              bram_reb,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [CNT_W-1:0]  bram_rd_data,
    output logic              lat_valid,
    output logic [CNT_W-1:0]  lat_value,
    output logic [CNT_W-1:0]  lat_min,
    output logic [CNT_W-1:0]  lat_max,
    output logic [53:0]       lat_sum,
    output logic [31:0]       lat_count,
    output logic [ADDR_W:0]   outstanding,
    output logic              err_unexpected
);
    localparam int unsigned SUM_W     = 54;
    localparam int unsigned SUM_EXT_W = SUM_W + 1;
    localparam int unsigned NUM_W     = 32;
    localparam int unsigned OUT_W     = ADDR_W + 1;
    localparam logic [OUT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, W1, W2} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [OUT_W-1:0]    outstanding_q;
    logic                bram_ena_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [CNT_W-1:0]    wr_data_q;
    logic                bram_reb_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [CNT_W-1:0]    t_rx_q;
    logic                lat_valid_q;
    logic [CNT_W-1:0]    lat_value_q;
    logic [CNT_W-1:0]    lat_min_q;
    logic [CNT_W-1:0]    lat_max_q;
    logic [SUM_W-1:0]    lat_sum_q;
    logic [NUM_W-1:0]    lat_count_q;
    logic                err_q;

    logic                send_acc;
    logic                echo_acc;
    logic                echo_ok;
    logic                echo_bad;
    logic [CNT_W-1:0]    lat_diff;
    logic [SUM_EXT_W-1:0] sum_ext;
    logic [SUM_W-1:0]    sum_next;
    logic [NUM_W-1:0]    count_next;

    assign tx_send_ready = (outstanding_q < DEPTH);
    assign rx_echo_ready = (state_q == IDLE);
    assign send_acc      = tx_send_valid && tx_send_ready;
    assign echo_acc      = rx_echo_valid && rx_echo_ready;
    assign echo_ok       = echo_acc && (outstanding_q != '0);
    assign echo_bad      = echo_acc && (outstanding_q == '0);

    // Modular subtraction gives the right answer across a timestamp wrap.
    assign lat_diff   = t_rx_q - bram_rd_data;
    assign sum_ext    = SUM_EXT_W'(lat_sum_q) + SUM_EXT_W'(lat_diff);
    assign sum_next   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    assign count_next = (&lat_count_q) ? lat_count_q : lat_count_q + NUM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            outstanding_q <= '0;
            bram_ena_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            bram_reb_q    <= 1'b0;
            rd_addr_q     <= '0;
            t_rx_q        <= '0;
            lat_valid_q   <= 1'b0;
            lat_value_q   <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
            lat_sum_q     <= '0;
            lat_count_q   <= '0;
            err_q         <= 1'b0;
        end else if (latency_reset_signal) begin
            // User clear wins over any send/echo this cycle and drops an in-flight read.
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            outstanding_q <= '0;
            bram_ena_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            bram_reb_q    <= 1'b0;
            rd_addr_q     <= '0;
            t_rx_q        <= '0;
            lat_valid_q   <= 1'b0;
            lat_value_q   <= '0;
            lat_min_q     <= '1;
            lat_max_q     <= '0;
            lat_sum_q     <= '0;
            lat_count_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            bram_ena_q  <= send_acc;
            bram_reb_q  <= 1'b0;
            lat_valid_q <= 1'b0;

            if (send_acc) begin
                wr_addr_q <= wr_ptr_q;
                wr_data_q <= latency_counter;
                wr_ptr_q  <= wr_ptr_q + ADDR_W'(1);
            end

            if (send_acc && !echo_ok) begin
                outstanding_q <= outstanding_q + OUT_W'(1);
            end else if (!send_acc && echo_ok) begin
                outstanding_q <= outstanding_q - OUT_W'(1);
            end

            if (echo_bad) begin
                err_q <= 1'b1;
            end

            // Read pipeline: RD issues the BRAM read, data lands in W2.
            case (state_q)
                IDLE: begin
                    if (echo_ok) begin
                        t_rx_q     <= latency_counter;
                        rd_addr_q  <= rx_echo_tag;
                        bram_reb_q <= 1'b1;
                        state_q    <= RD;
                    end
                end
                RD: state_q <= W1;
                W1: state_q <= W2;
                W2: begin
                    state_q     <= IDLE;
                    lat_valid_q <= 1'b1;
                    lat_value_q <= lat_diff;
                    lat_sum_q   <= sum_next;
                    lat_count_q <= count_next;
                    if (lat_diff < lat_min_q) lat_min_q <= lat_diff;
                    if (lat_diff > lat_max_q) lat_max_q <= lat_diff;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_tag         = wr_ptr_q;
    assign outstanding    = outstanding_q;
    assign bram_ena       = bram_ena_q;
    assign bram_wea       = bram_ena_q;
    assign bram_wr_addr   = wr_addr_q;
    assign bram_wr_data   = wr_data_q;
    assign bram_reb       = bram_reb_q;
    assign bram_rd_addr   = rd_addr_q;
    assign lat_valid      = lat_valid_q;
    assign lat_value      = lat_value_q;
    assign lat_min        = lat_min_q;
    assign lat_max        = lat_max_q;
    assign lat_sum        = lat_sum_q;
    assign lat_count      = lat_count_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_bmd_256_latency_ctrl.sv
// Scoreboard bench for bmd_256_latency_ctrl: stimulus predicts BRAM writes, reads and
// latency results into queues; a negedge monitor pops and compares them.
module tb_bmd_256_latency_ctrl;
    localparam int unsigned CNT_W  = 38;
    localparam int unsigned ADDR_W = 13;
    localparam int          DEPTH  = 8192;
    localparam longint      SUM_MAX = (64'd1 << 54) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              latency_reset_signal;
    logic [CNT_W-1:0]  latency_counter;
    logic              tx_send_valid;
    logic              tx_send_ready;
    logic [ADDR_W-1:0] tx_tag;
    logic              rx_echo_valid;
    logic              rx_echo_ready;
    logic [ADDR_W-1:0] rx_echo_tag;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_wr_addr;
    logic [CNT_W-1:0]  bram_wr_data;
    logic              bram_reb;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [CNT_W-1:0]  bram_rd_data;
    logic              lat_valid;
    logic [CNT_W-1:0]  lat_value;
    logic [CNT_W-1:0]  lat_min;
    logic [CNT_W-1:0]  lat_max;
    logic [53:0]       lat_sum;
    logic [31:0]       lat_count;
    logic [ADDR_W:0]   outstanding;
    logic              err_unexpected;

    bmd_256_latency_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .latency_reset_signal(latency_reset_signal),
        .latency_counter(latency_counter),
        .tx_send_valid(tx_send_valid), .tx_send_ready(tx_send_ready), .tx_tag(tx_tag),
        .rx_echo_valid(rx_echo_valid), .rx_echo_ready(rx_echo_ready), .rx_echo_tag(rx_echo_tag),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_wr_addr(bram_wr_addr),
        .bram_wr_data(bram_wr_data), .bram_reb(bram_reb), .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data), .lat_valid(lat_valid), .lat_value(lat_value),
        .lat_min(lat_min), .lat_max(lat_max), .lat_sum(lat_sum), .lat_count(lat_count),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    always #2 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port BRAM with two-cycle read latency.
    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] rd_p1;
    always @(posedge clk) begin
        if (bram_ena && bram_wea) mem[bram_wr_addr] <= bram_wr_data;
        if (bram_reb) rd_p1 <= mem[bram_rd_addr];
        bram_rd_data <= rd_p1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  data;
        int                epoch;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    exp_t lq[$];

    // Reference model state
    int                m_out = 0;
    logic [ADDR_W-1:0] m_wr_ptr = '0;
    int                m_busy_until = 0;
    bit                m_err = 1'b0;
    int                epoch = 0;
    logic [CNT_W-1:0]  m_ts [DEPTH];
    logic [ADDR_W-1:0] inflight[$];

    // One clock of stimulus: check visible state, drive inputs, advance the model.
    task automatic step(input bit sv, input bit ev, input logic [ADDR_W-1:0] etag, input bit clr);
        bit   s_rdy;
        bit   e_rdy;
        exp_t e;
        s_rdy = (m_out < DEPTH);
        e_rdy = (cyc >= m_busy_until);
        chk("tx_send_ready", 64'(tx_send_ready), 64'(s_rdy));
        chk("rx_echo_ready", 64'(rx_echo_ready), 64'(e_rdy));
        chk("outstanding", 64'(outstanding), 64'(m_out));
        chk("tx_tag", 64'(tx_tag), 64'(m_wr_ptr));
        chk("err_unexpected", 64'(err_unexpected), 64'(m_err));
        tx_send_valid        = sv;
        rx_echo_valid        = ev;
        rx_echo_tag          = etag;
        latency_reset_signal = clr;
        if (clr) begin
            m_out = 0; m_wr_ptr = '0; m_err = 1'b0; m_busy_until = 0;
            epoch++;
            inflight.delete();
            for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc > cyc) rq.delete(i);
            for (int i = lq.size() - 1; i >= 0; i--) if (lq[i].cyc > cyc) lq.delete(i);
        end else begin
            if (ev && e_rdy) begin
                if (m_out == 0) begin
                    m_err = 1'b1;
                end else begin
                    e.cyc = cyc + 1; e.addr = etag; e.data = '0; e.epoch = epoch;
                    rq.push_back(e);
                    e.cyc = cyc + 4; e.data = latency_counter - m_ts[etag];
                    lq.push_back(e);
                    m_busy_until = cyc + 4;
                    m_out--;
                    for (int i = 0; i < inflight.size(); i++) begin
                        if (inflight[i] == etag) begin
                            inflight.delete(i);
                            break;
                        end
                    end
                end
            end
            if (sv && s_rdy) begin
                e.cyc = cyc + 1; e.addr = m_wr_ptr; e.data = latency_counter; e.epoch = epoch;
                wq.push_back(e);
                m_ts[m_wr_ptr] = latency_counter;
                inflight.push_back(m_wr_ptr);
                m_wr_ptr = m_wr_ptr + ADDR_W'(1);
                m_out++;
            end
        end
        @(posedge clk);
        #1;
        latency_counter = latency_counter + CNT_W'(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor-side statistics, rebuilt from expected latencies
    logic [CNT_W-1:0] mm_min = '1;
    logic [CNT_W-1:0] mm_max = '0;
    longint           mm_sum = 0;
    longint           mm_cnt = 0;
    int               mon_epoch = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                chk("bram_wr_missing", 64'(cyc), 64'(wq[0].cyc));
                void'(wq.pop_front());
            end
            if (bram_ena || bram_wea) begin
                if (wq.size() == 0) chk("bram_wr_spurious", 64'({bram_ena, bram_wea}), 64'(0));
                else begin
                    e = wq.pop_front();
                    chk("bram_wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("bram_ena_wea", 64'({bram_ena, bram_wea}), 64'(3));
                    chk("bram_wr_addr", 64'(bram_wr_addr), 64'(e.addr));
                    chk("bram_wr_data", 64'(bram_wr_data), 64'(e.data));
                end
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("bram_rd_missing", 64'(cyc), 64'(rq[0].cyc));
                void'(rq.pop_front());
            end
            if (bram_reb) begin
                if (rq.size() == 0) chk("bram_reb_spurious", 64'(bram_reb), 64'(0));
                else begin
                    e = rq.pop_front();
                    chk("bram_rd_cycle", 64'(cyc), 64'(e.cyc));
                    chk("bram_rd_addr", 64'(bram_rd_addr), 64'(e.addr));
                end
            end
            while (lq.size() > 0 && lq[0].cyc < cyc) begin
                chk("lat_valid_missing", 64'(cyc), 64'(lq[0].cyc));
                void'(lq.pop_front());
            end
            if (lat_valid) begin
                if (lq.size() == 0) chk("lat_valid_spurious", 64'(lat_valid), 64'(0));
                else begin
                    e = lq.pop_front();
                    if (e.epoch != mon_epoch) begin
                        mon_epoch = e.epoch;
                        mm_min = '1; mm_max = '0; mm_sum = 0; mm_cnt = 0;
                    end
                    if (e.data < mm_min) mm_min = e.data;
                    if (e.data > mm_max) mm_max = e.data;
                    mm_sum = mm_sum + longint'(e.data);
                    if (mm_sum > SUM_MAX) mm_sum = SUM_MAX;
                    if (mm_cnt < 64'hFFFF_FFFF) mm_cnt++;
                    chk("lat_cycle", 64'(cyc), 64'(e.cyc));
                    chk("lat_value", 64'(lat_value), 64'(e.data));
                    chk("lat_min", 64'(lat_min), 64'(mm_min));
                    chk("lat_max", 64'(lat_max), 64'(mm_max));
                    chk("lat_sum", 64'(lat_sum), 64'(mm_sum));
                    chk("lat_count", 64'(lat_count), 64'(mm_cnt));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit                sv;
        bit                ev;
        bit                clr;
        logic [ADDR_W-1:0] tg;
        logic [CNT_W-1:0]  ones;
        ones = '1;
        rst_n = 1'b0;
        latency_reset_signal = 1'b0;
        tx_send_valid = 1'b0;
        rx_echo_valid = 1'b0;
        rx_echo_tag = '0;
        latency_counter = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bram_en", 64'({bram_ena, bram_wea, bram_reb}), 64'(0));
        chk("rst_bram_addr_data", 64'(bram_wr_addr) | 64'(bram_wr_data) | 64'(bram_rd_addr), 64'(0));
        chk("rst_lat_valid", 64'(lat_valid), 64'(0));
        chk("rst_lat_value", 64'(lat_value), 64'(0));
        chk("rst_lat_min", 64'(lat_min), 64'(ones));
        chk("rst_lat_max", 64'(lat_max), 64'(0));
        chk("rst_lat_sum", 64'(lat_sum), 64'(0));
        chk("rst_lat_count", 64'(lat_count), 64'(0));
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_err", 64'(err_unexpected), 64'(0));
        chk("rst_ready", 64'({tx_send_ready, rx_echo_ready}), 64'(3));
        chk("rst_tx_tag", 64'(tx_tag), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single echo: sent at 100, echoed at 350
        latency_counter = CNT_W'(100);
        step(1'b1, 1'b0, '0, 1'b0);
        idle(2);
        latency_counter = CNT_W'(350);
        step(1'b0, 1'b1, 13'd0, 1'b0);
        idle(5);
        chk("single_lat_value", 64'(lat_value), 64'(250));
        chk("single_lat_min", 64'(lat_min), 64'(250));
        chk("single_lat_max", 64'(lat_max), 64'(250));
        chk("single_lat_count", 64'(lat_count), 64'(1));

        // Timestamp wrap
        latency_counter = 38'h3F_FFFF_FFF6;
        step(1'b1, 1'b0, '0, 1'b0);
        latency_counter = CNT_W'(5);
        step(1'b0, 1'b1, 13'd1, 1'b0);
        idle(5);
        chk("wrap_lat_value", 64'(lat_value), 64'(15));

        // Unexpected echo with nothing outstanding
        step(1'b0, 1'b1, 13'd5, 1'b0);
        idle(5);
        chk("unexp_err", 64'(err_unexpected), 64'(1));
        chk("unexp_count", 64'(lat_count), 64'(2));

        // Simultaneous send+echo, then clear right after an echo accept
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 13'd2, 1'b0);
        chk("simul_outstanding", 64'(outstanding), 64'(1));
        idle(4);
        step(1'b0, 1'b1, 13'd3, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(6);
        chk("clr_lat_count", 64'(lat_count), 64'(0));
        chk("clr_lat_min", 64'(lat_min), 64'(ones));
        chk("clr_lat_max", 64'(lat_max), 64'(0));
        chk("clr_lat_sum", 64'(lat_sum), 64'(0));
        chk("clr_tx_tag", 64'(tx_tag), 64'(0));
        chk("clr_outstanding", 64'(outstanding), 64'(0));
        chk("clr_err", 64'(err_unexpected), 64'(0));

        // Fill all tags without echoes
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 1'b0);
        chk("full_ready", 64'(tx_send_ready), 64'(0));
        chk("full_outstanding", 64'(outstanding), 64'(DEPTH));
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 13'd0, 1'b0);
        chk("full_ready_after_echo", 64'(tx_send_ready), 64'(1));
        chk("full_next_tag", 64'(tx_tag), 64'(0));
        step(1'b1, 1'b0, '0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(2);

        // Randomized traffic with counter jumps, a counter wrap and occasional clears
        latency_counter = 38'h3F_FFFF_F000;
        for (int i = 0; i < 3000; i++) begin
            sv  = ($urandom_range(0, 99) < 45);
            ev  = ($urandom_range(0, 99) < 40);
            clr = ($urandom_range(0, 999) < 3);
            if (inflight.size() > 0) tg = inflight[$urandom_range(0, inflight.size() - 1)];
            else tg = ADDR_W'($urandom);
            if ($urandom_range(0, 49) == 0)
                latency_counter = latency_counter + CNT_W'($urandom_range(0, 20000));
            step(sv, ev, tg, clr);
        end
        idle(10);
        chk("drain_wr", 64'(wq.size()), 64'(0));
        chk("drain_rd", 64'(rq.size()), 64'(0));
        chk("drain_lat", 64'(lq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
